// File: rtl/mod_step_counter.sv
// Modulo up/down step counter with load, clamping, wrap pulse and at-max flag.
// Advances on a one-cycle step strobe or on the rising edge of a debounced push-button.
module mod_step_counter #(
    parameter int WIDTH        = 10,
    parameter int DB_BITS      = 16,
    parameter int USE_DEBOUNCE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             step,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max,
    output logic             btn_level
);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_d;
    logic             btn_pulse;
    logic             adv;
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;

    // Two-flop synchroniser; sync_q2 is the clean sampled button level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    generate
        if (USE_DEBOUNCE != 0) begin : g_debounce
            logic [DB_BITS-1:0] db_cnt;
            logic               level_q;

            // Level only flips after 2^DB_BITS consecutive disagreeing samples.
            always_ff @(posedge clock) begin
                if (reset) begin
                    db_cnt  <= '0;
                    level_q <= 1'b0;
                end else if (sync_q2 == level_q) begin
                    db_cnt <= '0;
                end else if (&db_cnt) begin
                    level_q <= sync_q2;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_BITS'(1);
                end
            end

            assign btn_level = level_q;
        end else begin : g_bypass
            assign btn_level = sync_q2;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            level_d <= 1'b0;
        end else begin
            level_d <= btn_level;
        end
    end

    // Press (rising edge) only; release is not an event.
    assign btn_pulse = btn_level & ~level_d;
    assign adv       = btn_pulse | step;
    assign at_max    = (count == max);

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = (load_value > max) ? max : load_value;
        end else if (adv) begin
            if (up_down) begin
                // count >= max wraps before count + 1 could overflow.
                if (count >= max) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    count_next = max;
                    wrap_next  = 1'b1;
                end else if (count > max) begin
                    count_next = max;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_mod_step_counter.sv
// Bench for mod_step_counter: a debounced instance (DB_BITS=4) and a bypass instance
// share all inputs; a behavioural model feeds an expected queue drained by a monitor.
module tb_mod_step_counter;

    localparam int W       = 10;
    localparam int DB      = 4;
    localparam int RUN_LEN = 1 << DB;
    localparam int EW      = 2 * (W + 3);

    logic         clock;
    logic         reset;
    logic         btn_raw;
    logic         step;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] max;

    logic [W-1:0] count_a, count_b;
    logic         wrap_a, wrap_b;
    logic         at_max_a, at_max_b;
    logic         btn_level_a, btn_level_b;

    mod_step_counter #(.WIDTH(W), .DB_BITS(DB), .USE_DEBOUNCE(1)) dut_a (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .step(step),
        .up_down(up_down), .load(load), .load_value(load_value), .max(max),
        .count(count_a), .wrap(wrap_a), .at_max(at_max_a), .btn_level(btn_level_a)
    );

    mod_step_counter #(.WIDTH(W), .DB_BITS(DB), .USE_DEBOUNCE(0)) dut_b (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .step(step),
        .up_down(up_down), .load(load), .load_value(load_value), .max(max),
        .count(count_b), .wrap(wrap_b), .at_max(at_max_b), .btn_level(btn_level_b)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounced path: s = raw delayed two cycles; level flips after RUN_LEN
    // consecutive cycles of s disagreeing with it.
    bit a_q1, a_q2, a_lvl, a_lvl_d, a_wrap;
    int a_run, a_cnt;
    // Bypass path: level is s itself.
    bit b_q1, b_q2, b_s_d, b_wrap;
    int b_cnt;

    task automatic model_count(input int c, input bit adv, output int c_n, output bit w_n);
        int mx;
        mx  = int'(max);
        c_n = c;
        w_n = 1'b0;
        if (load) begin
            c_n = (int'(load_value) > mx) ? mx : int'(load_value);
        end else if (adv && up_down) begin
            w_n = (c >= mx);
            c_n = w_n ? 0 : c + 1;
        end else if (adv) begin
            if (c == 0) begin
                c_n = mx;
                w_n = 1'b1;
            end else begin
                c_n = (c > mx) ? mx : c - 1;
            end
        end
    endtask

    task automatic do_cycle();
        bit pa, pb;
        logic [W-1:0] ca, cb;
        @(posedge clock);
        if (reset) begin
            a_q1 = 0; a_q2 = 0; a_lvl = 0; a_lvl_d = 0; a_run = 0; a_cnt = 0; a_wrap = 0;
            b_q1 = 0; b_q2 = 0; b_s_d = 0; b_cnt = 0; b_wrap = 0;
        end else begin
            pa = a_lvl && !a_lvl_d;
            model_count(a_cnt, pa || step, a_cnt, a_wrap);
            a_lvl_d = a_lvl;
            if (a_q2 != a_lvl) begin
                a_run++;
                if (a_run == RUN_LEN) begin
                    a_lvl = a_q2;
                    a_run = 0;
                end
            end else begin
                a_run = 0;
            end
            a_q2 = a_q1;
            a_q1 = btn_raw;

            pb = b_q2 && !b_s_d;
            model_count(b_cnt, pb || step, b_cnt, b_wrap);
            b_s_d = b_q2;
            b_q2  = b_q1;
            b_q1  = btn_raw;
        end
        ca = W'(a_cnt);
        cb = W'(b_cnt);
        exp_q.push_back({ca, a_wrap, (a_cnt == int'(max)), a_lvl,
                         cb, b_wrap, (b_cnt == int'(max)), b_q2});
        @(negedge clock);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("count_a",     int'(count_a),     int'(e[25:16]));
                check("wrap_a",      int'(wrap_a),      int'(e[15]));
                check("at_max_a",    int'(at_max_a),    int'(e[14]));
                check("btn_level_a", int'(btn_level_a), int'(e[13]));
                check("count_b",     int'(count_b),     int'(e[12:3]));
                check("wrap_b",      int'(wrap_b),      int'(e[2]));
                check("at_max_b",    int'(at_max_b),    int'(e[1]));
                check("btn_level_b", int'(btn_level_b), int'(e[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        step = 1'b0;
        load = 1'b0;
        repeat (n) do_cycle();
    endtask

    task automatic pulse_step(input bit dir);
        up_down = dir;
        step    = 1'b1;
        do_cycle();
        step = 1'b0;
        do_cycle();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) do_cycle();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        reset = 1'b1; btn_raw = 1'b0; step = 1'b0; up_down = 1'b1;
        load = 1'b0; load_value = '0; max = '0;
        do_reset(3);

        // Up count 0..5 with wrap.
        max = 10'd5;
        repeat (7) pulse_step(1'b1);

        // Down from 0 wraps to max.
        do_reset(1);
        repeat (3) pulse_step(1'b0);

        // Load clamps and beats a coincident step.
        load = 1'b1; load_value = 10'd900; max = 10'd600; step = 1'b1; up_down = 1'b1;
        do_cycle();
        load = 1'b0; step = 1'b0;
        do_cycle();
        check("load_clamp", int'(count_a), 600);
        max = 10'd10;
        pulse_step(1'b1);
        check("lowered_max_wrap", int'(count_a), 0);

        // max = 0: every step wraps.
        max = '0;
        repeat (4) pulse_step(1'b1);

        // Bouncing button must not register.
        max = 10'd20;
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            btn_raw = ~btn_raw;
            repeat (5) do_cycle();
        end
        check("bounce_no_count", int'(count_a), 0);

        // Held press: one increment, 19 edges after the rise.
        btn_raw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 25; i++) begin
            do_cycle();
            if (lat == 0 && count_a != '0) lat = i;
        end
        check("debounce_latency", lat, 19);
        btn_raw = 1'b0;
        idle(25);
        check("release_no_count", int'(count_a), 1);

        // Bypass: three-cycle press gives one increment after 3 edges.
        do_reset(1);
        btn_raw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 3; i++) begin
            do_cycle();
            if (lat == 0 && count_b != '0) lat = i;
        end
        btn_raw = 1'b0;
        idle(6);
        check("bypass_latency", lat, 3);
        check("bypass_single", int'(count_b), 1);

        // Reset part-way through a debounce discards it.
        do_reset(1);
        btn_raw = 1'b1;
        repeat (10) do_cycle();
        do_reset(1);
        btn_raw = 1'b0;
        idle(20);
        check("mid_reset_level", int'(btn_level_a), 0);
        check("mid_reset_count", int'(count_a), 0);

        // Button held through reset re-debounces in full.
        btn_raw = 1'b1;
        do_reset(1);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            do_cycle();
            if (lat == 0 && btn_level_a) lat = i;
        end
        check("redebounce_latency", lat, 18);
        btn_raw = 1'b0;
        idle(25);

        // Randomised traffic.
        for (int i = 0; i < 700; i++) begin
            step       = ($urandom_range(0, 3) == 0);
            up_down    = 1'($urandom_range(0, 1));
            load       = ($urandom_range(0, 24) == 0);
            load_value = W'($urandom_range(0, 1023));
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: max = '0;
                    1: max = 10'd1;
                    2: max = 10'd1023;
                    3: max = W'($urandom_range(0, 15));
                    default: max = W'($urandom_range(0, 1023));
                endcase
            end
            if ($urandom_range(0, 29) == 0) btn_raw = ~btn_raw;
            reset = ($urandom_range(0, 299) == 0);
            do_cycle();
        end
        reset = 1'b0;
        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
